// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC time-division scheduler.
//   phase_t    : signed 1.2.13 phase word (range PI_NEG..PI_POS)
//   tag_t      : channel tag that travels alongside each CORDIC operation
//   phase_wrap : one accumulator step with wrap into [PI_NEG, PI_POS]
package cordic_pkg;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned TAG_CHW = 4;  // covers up to 16 channels

  localparam logic signed [PHASE_W-1:0] PI_POS = 16'sh6488;
  localparam logic signed [PHASE_W-1:0] PI_NEG = 16'sh9B78;
  localparam logic [PHASE_W:0]          TWO_PI = 17'd51472;

  typedef logic signed [PHASE_W-1:0] phase_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_CHW-1:0] ch;
  } tag_t;

  // acc + inc at 17 bits; anything past +pi folds back by one full turn.
  function automatic phase_t phase_wrap(input phase_t acc, input logic [PHASE_W-1:0] inc);
    logic signed [PHASE_W:0] sum;
    sum = $signed({acc[PHASE_W-1], acc}) + $signed({1'b0, inc});
    if (sum > $signed({PI_POS[PHASE_W-1], PI_POS})) begin
      sum = sum - $signed(TWO_PI);
    end
    return phase_t'(sum[PHASE_W-1:0]);
  endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Fixed-depth shift register of channel tags, matched to the CORDIC latency.
//   clk  : clock
//   clr  : synchronous clear of every stage
//   din  : tag entering the line
//   dout : tag leaving the line, DEPTH clocks after entry
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 20
) (
  input  logic clk,
  input  logic clr,
  input  tag_t din,
  output tag_t dout
);

  tag_t line [DEPTH];

  // Shifts every clock; the CORDIC has no backpressure, so neither does this.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line[i] <= '0;
      end
    end else begin
      line[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/cordic_tdm_scheduler.sv
// Round-robin scheduler sharing one CORDIC sin/cos core among NCH tone channels.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : issue one channel per clock while high
//   cfg_we/ch/inc      : per-channel phase increment write
//   sync               : zero all phase accumulators
//   m_phase_tvalid/data: phase stream to the CORDIC
//   s_dout_tvalid/sin/cos : samples returning from the CORDIC
//   ch_sin, ch_cos     : per-channel latest samples, channel k at [k*OW +: OW]
//   ch_valid           : per-channel update strobe
//   err                : sticky tag/valid mismatch
module cordic_tdm_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 16,
  parameter int unsigned OW  = 12,
  parameter int unsigned LAT = 20,
  parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [PW-1:0]     cfg_inc,
  input  logic              sync,
  output logic              m_phase_tvalid,
  output logic [PW-1:0]     m_phase_tdata,
  input  logic              s_dout_tvalid,
  input  logic [OW-1:0]     s_dout_sin,
  input  logic [OW-1:0]     s_dout_cos,
  output logic [NCH*OW-1:0] ch_sin,
  output logic [NCH*OW-1:0] ch_cos,
  output logic [NCH-1:0]    ch_valid,
  output logic              err
);

  localparam int unsigned DW = $clog2(LAT + 1);

  phase_t         acc [NCH];
  logic [PW-1:0]  inc [NCH];
  logic [CHW-1:0] slot;
  logic [DW-1:0]  drain;
  tag_t           tag_q;
  tag_t           tag_out;

  // Round-robin slot; holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (en) begin
      if (slot == CHW'(NCH - 1)) begin
        slot <= '0;
      end else begin
        slot <= slot + CHW'(1);
      end
    end
  end

  // Accumulators and increments; sync overrides the issue update,
  // and a same-cycle config write only takes effect on the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        inc[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (sync) begin
          acc[k] <= '0;
        end else if (en && (slot == CHW'(k))) begin
          acc[k] <= phase_wrap(acc[k], inc[k]);
        end
        if (cfg_we && (cfg_ch == CHW'(k))) begin
          inc[k] <= cfg_inc;
        end
      end
    end
  end

  // Phase issue plus the stage-0 tag that sits alongside m_phase_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_phase_tvalid <= 1'b0;
      m_phase_tdata  <= '0;
      tag_q          <= '0;
    end else begin
      m_phase_tvalid <= en;
      if (en) begin
        m_phase_tdata <= acc[slot];
      end
      tag_q.valid <= en;
      tag_q.ch    <= TAG_CHW'(slot);
    end
  end

  // LAT further stages bring the tag into line with s_dout_tvalid.
  cordic_tag_pipe #(
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_q),
    .dout (tag_out)
  );

  // Drain window: results of operations launched before reset are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain <= DW'(LAT);
    end else if (drain != '0) begin
      drain <= drain - DW'(1);
    end
  end

  // Output demux and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sin   <= '0;
      ch_cos   <= '0;
      ch_valid <= '0;
      err      <= 1'b0;
    end else begin
      ch_valid <= '0;
      if (drain == '0) begin
        if (s_dout_tvalid != tag_out.valid) begin
          err <= 1'b1;
        end
        if (s_dout_tvalid && tag_out.valid) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (tag_out.ch == TAG_CHW'(k)) begin
              ch_sin[k*OW +: OW] <= s_dout_sin;
              ch_cos[k*OW +: OW] <= s_dout_cos;
              ch_valid[k]        <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/cordic_tdm_scheduler.md
Name: cordic_tdm_scheduler

Overview:
- Time-division scheduler that shares one free-running CORDIC sin/cos core among NCH independent tone channels.
- Keeps one phase accumulator and one phase increment per channel, and issues one phase per clock in round-robin order.
- Tags each issued phase with its channel ID through a delay line matched to the CORDIC latency.
- Demultiplexes the returned sin/cos samples into per-channel holding registers with valid strobes.
- Sits between the configuration/control logic and the CORDIC wrapper in the wave-synthesis path.

Parameters:
- NCH, 4: number of channels (2..16).
- PW, 16: phase width. Fixed-point 1.2.13 (sign + 2 integer + 13 fraction bits). Only 16 is supported.
- OW, 12: sample width of the CORDIC sin/cos outputs.
- LAT, 20: CORDIC latency in clocks, from phase tvalid accepted to dout tvalid.
- CHW, $clog2(NCH): channel-index width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; while high, one channel is issued per clock
- cfg_we  in  1  increment write strobe
- cfg_ch  in  CHW  channel index for cfg_we
- cfg_inc  in  PW  phase increment. Unsigned-valued, legal range 0..PI_POS.
- sync  in  1  one-cycle pulse; zeroes all phase accumulators
- m_phase_tvalid  out  1  to CORDIC s_axis_phase_tvalid
- m_phase_tdata  out  PW  to CORDIC s_axis_phase_tdata
- s_dout_tvalid  in  1  from CORDIC m_axis_dout_tvalid
- s_dout_sin  in  OW  CORDIC sine (signed)
- s_dout_cos  in  OW  CORDIC cosine (signed)
- ch_sin  out  NCH*OW  per-channel latest sine; channel k occupies bits [k*OW +: OW]
- ch_cos  out  NCH*OW  per-channel latest cosine, same packing
- ch_valid  out  NCH  one-cycle strobe per channel when its sample updates
- err  out  1  sticky tag/valid mismatch flag

Behaviour:
- Reset values (reset is synchronous, active-high, clock clk): accumulators, increments, slot, tags, m_phase_*, ch_sin, ch_cos, ch_valid and err all 0. Drain counter loaded with LAT.
- Slot counter: when en=1, it increments 0..NCH-1 and wraps to 0 each clock. When en=0, it holds.
- Issue: in a cycle with en=1 and slot=s, register m_phase_tdata<=acc[s] and m_phase_tvalid<=1. Push tag {1,s} into the LAT-deep tag line. In the same edge, update acc[s]. When en=0, m_phase_tvalid<=0 and push tag {0,x}.
- Accumulator update: sum = acc + inc, computed at PW+1 bits. If sum > PI_POS, acc <= sum - TWO_PI; otherwise acc <= sum. acc therefore always lies in [PI_NEG, PI_POS].
  - Example: acc=0x6000 with inc=0x1000 gives 0x9B78 - 0x6488 + 0x7000 ... concretely sum=28672 → 28672 - 51472 = -22800 = 0xA6F0.
- Config write: inc[cfg_ch] <= cfg_inc at the clock edge. If channel cfg_ch is issued in the same cycle, that issue and its accumulator update use the old increment. cfg_ch >= NCH is ignored.
- sync: all acc <= 0, and this takes priority over the concurrent update. The issued phase in the sync cycle is still the pre-sync value.
- Tag line: shifts every clock regardless of en, because the CORDIC has no backpressure. The output tag t = tag line stage LAT, aligned with s_dout_tvalid.
- Demux: if s_dout_tvalid=1 and t.valid=1, write ch_sin[t.ch] and ch_cos[t.ch] and pulse ch_valid[t.ch] on the next edge. Latency from issue to ch_valid is LAT+1 clocks, i.e. LAT+2 clocks after the first en-high cycle.
- Error: err <= 1 if s_dout_tvalid differs from t.valid while drain counter = 0. err clears only on rst.
- Drain counter: decrements to 0 after reset. While it is nonzero, CORDIC outputs from operations in flight before reset are discarded, with no ch_valid and no err.
- NCH=1: slot is constant 0 and every cycle issues channel 0.

Decomposition:
- Package cordic_pkg:
  - PI_POS=16'sh6488, PI_NEG=16'sh9B78, TWO_PI=17'd51472
  - phase_t (signed [15:0])
  - tag_t struct {valid, ch}
- Sub-module cordic_tag_pipe: parameterised LAT-deep shift register of tag_t, with synchronous clear.

Test Plan:
Use a bench CORDIC model: LAT-cycle delay plus real sin/cos quantised to OW bits.
- Reset then en=1 with inc={0x0100,0x0200,0x0400,0x0800}: m_phase_tdata sequence on ch0 is 0, 0x0100, 0x0200… at one sample per 4 clocks; first ch_valid[0] arrives 22 clocks after en rises.
- inc[0]=0x6488 (pi): ch0 phases go 0, 0x6488, then wrap to 0 (51472-51472). ch_cos[0] alternates +max/−max; no value outside [PI_NEG,PI_POS] is ever issued.
- cfg_we to ch2 in the same cycle ch2 is issued: the next ch2 phase reflects the old inc; the one after that reflects the new inc.
- sync pulse mid-run: every channel's next issued phase is 0. ch_valid continues without a gap.
- en low for 7 cycles: m_phase_tvalid is low for 7 cycles; exactly 7 cycles of ch_valid are absent LAT+1 later. Round-robin order resumes at the held slot.
- Assert rst for 1 cycle while LAT samples are in flight: no ch_valid and err=0 for the next LAT cycles. Injecting a spurious s_dout_tvalid afterwards sets err=1.
